// File: rtl/riscv_regfile_dbg_axil.sv
// -----------------------------------------------------------------------------
// riscv_regfile_dbg_axil
//
// AXI4-Lite slave that gives an external debug master read/write access to
// x0-x31 of the core register file. Only one transaction is in flight at a
// time. This block drives the register-file ports; core control muxes those
// ports onto the register file only while the core is halted.
//
// Handshake rule (all five AXI channels): a transfer happens on the rising
// clock edge where valid and ready are both 1. Once this slave raises
// s_bvalid or s_rvalid, it holds that valid and its response fields stable
// until the matching ready is seen.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   s_aw*/s_w*/s_b*       AXI-Lite write address / data / response channels
//   s_ar*/s_r*            AXI-Lite read address / data channels
//   core_halted           core is stopped; sampled only while executing
//   rf_raddr, rf_rdata    register-file read port (rf_rdata is combinational)
//   rf_waddr, rf_wdata,   register-file write port; rf_we is a one-cycle
//   rf_we                 pulse
//
// Address map: bits [6:2] select the register. Any set bit in
// [ADDR_WIDTH-1:7] gives DECERR. When REQUIRE_HALT is set, an access made
// while the core is running gives SLVERR and has no side effect.
//
// The FSM state is held in the named enum signal state_q.
// -----------------------------------------------------------------------------
module riscv_regfile_dbg_axil #(
  parameter int ADDR_WIDTH   = 12,
  parameter bit REQUIRE_HALT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  input  logic                  core_halted,
  output logic [4:0]            rf_raddr,
  input  logic [31:0]           rf_rdata,
  output logic [4:0]            rf_waddr,
  output logic [31:0]           rf_wdata,
  output logic                  rf_we
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WCAP  = 3'd1,
    S_WEXEC = 3'd2,
    S_WRESP = 3'd3,
    S_REXEC = 3'd4,
    S_RRESP = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Captured request. Only the register index and the "upper bits nonzero"
  // flag matter, so the full address is not stored.
  logic        aw_got_q, w_got_q;
  logic [4:0]  widx_q, ridx_q;
  logic        waddr_err_q, raddr_err_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;

  // Byte-offset bits are ignored by design.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

  // ---------------------------------------------------------------------------
  // Ready generation. Readies are forced low while reset is asserted.
  // ---------------------------------------------------------------------------
  logic capture_phase;
  logic aw_hs, w_hs, ar_hs;
  logic aw_have, w_have;

  assign capture_phase = (state_q == S_IDLE) || (state_q == S_WCAP);

  assign s_awready = !rst && capture_phase && !aw_got_q;
  assign s_wready  = !rst && capture_phase && !w_got_q;
  // A read is accepted only when no write is captured or being offered, so
  // writes win simultaneous arrivals.
  assign s_arready = !rst && (state_q == S_IDLE) && !aw_got_q && !w_got_q &&
                     !s_awvalid && !s_wvalid;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid  && s_wready;
  assign ar_hs = s_arvalid && s_arready;

  assign aw_have = aw_got_q || aw_hs;
  assign w_have  = w_got_q  || w_hs;

  // ---------------------------------------------------------------------------
  // Execute-cycle decode, shared by reads and writes.
  // ---------------------------------------------------------------------------
  logic        exec_is_read;
  logic [4:0]  exec_idx;
  logic        exec_addr_err;
  logic        exec_halt_err;
  logic [1:0]  exec_resp;
  logic [31:0] merged_wdata;

  assign exec_is_read  = (state_q == S_REXEC);
  assign exec_idx      = exec_is_read ? ridx_q : widx_q;
  assign exec_addr_err = exec_is_read ? raddr_err_q : waddr_err_q;
  assign exec_halt_err = REQUIRE_HALT && !core_halted;

  always_comb begin
    exec_resp = RESP_OKAY;
    if (exec_addr_err) begin
      exec_resp = RESP_DECERR;
    end else if (exec_halt_err) begin
      exec_resp = RESP_SLVERR;
    end
  end

  // Read-modify-write: unstrobed bytes keep the current register value.
  always_comb begin
    merged_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      merged_wdata[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : rf_rdata[8*i +: 8];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (aw_hs && w_hs) begin
          state_d = S_WEXEC;
        end else if (aw_hs || w_hs) begin
          state_d = S_WCAP;
        end else if (ar_hs) begin
          state_d = S_REXEC;
        end
      end
      S_WCAP: begin
        if (aw_have && w_have) begin
          state_d = S_WEXEC;
        end
      end
      S_WEXEC: state_d = S_WRESP;
      S_WRESP: begin
        if (s_bready) begin
          state_d = S_IDLE;
        end
      end
      S_REXEC: state_d = S_RRESP;
      S_RRESP: begin
        if (s_rready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: register-file port outputs (all zero outside the execute cycles).
  always_comb begin
    rf_raddr = '0;
    rf_waddr = '0;
    rf_wdata = '0;
    rf_we    = 1'b0;
    case (state_q)
      S_WEXEC: begin
        rf_raddr = exec_idx;
        rf_waddr = exec_idx;
        rf_wdata = merged_wdata;
        // x0 is hardwired, so a write to index 0 is acknowledged but dropped.
        rf_we    = (exec_resp == RESP_OKAY) && (wstrb_q != 4'b0000) &&
                   (exec_idx != 5'd0);
      end
      S_REXEC: begin
        rf_raddr = exec_idx;
      end
      default: ;
    endcase
  end

  assign s_bvalid = (state_q == S_WRESP);
  assign s_rvalid = (state_q == S_RRESP);
  assign s_bresp  = bresp_q;
  assign s_rresp  = rresp_q;
  assign s_rdata  = rdata_q;

  // ---------------------------------------------------------------------------
  // Capture and response registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got_q    <= 1'b0;
      w_got_q     <= 1'b0;
      widx_q      <= '0;
      ridx_q      <= '0;
      waddr_err_q <= 1'b0;
      raddr_err_q <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      bresp_q     <= RESP_OKAY;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
    end else begin
      if (aw_hs) begin
        aw_got_q    <= 1'b1;
        widx_q      <= s_awaddr[6:2];
        waddr_err_q <= |s_awaddr[ADDR_WIDTH-1:7];
      end
      if (w_hs) begin
        w_got_q <= 1'b1;
        wdata_q <= s_wdata;
        wstrb_q <= s_wstrb;
      end
      if (ar_hs) begin
        ridx_q      <= s_araddr[6:2];
        raddr_err_q <= |s_araddr[ADDR_WIDTH-1:7];
      end
      if (state_q == S_WEXEC) begin
        aw_got_q <= 1'b0;
        w_got_q  <= 1'b0;
        bresp_q  <= exec_resp;
      end
      if (state_q == S_REXEC) begin
        rresp_q <= exec_resp;
        rdata_q <= (exec_resp == RESP_OKAY) ? rf_rdata : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_regfile_dbg_axil.sv
// -----------------------------------------------------------------------------
// tb_riscv_regfile_dbg_axil
//
// Directed bench for riscv_regfile_dbg_axil. The bench owns a register-file
// array that the DUT reads and writes. A separate model (model_rf plus the
// address/halt rules) predicts every register write and every response.
// One monitor checks the DUT against those predictions on each falling edge.
// -----------------------------------------------------------------------------
module tb_riscv_regfile_dbg_axil;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [11:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic        core_halted;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_we;

  always #5 clk = ~clk;

  riscv_regfile_dbg_axil #(
    .ADDR_WIDTH   (12),
    .REQUIRE_HALT (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_awaddr    (s_awaddr),
    .s_awvalid   (s_awvalid),
    .s_awready   (s_awready),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_wvalid    (s_wvalid),
    .s_wready    (s_wready),
    .s_bresp     (s_bresp),
    .s_bvalid    (s_bvalid),
    .s_bready    (s_bready),
    .s_araddr    (s_araddr),
    .s_arvalid   (s_arvalid),
    .s_arready   (s_arready),
    .s_rdata     (s_rdata),
    .s_rresp     (s_rresp),
    .s_rvalid    (s_rvalid),
    .s_rready    (s_rready),
    .core_halted (core_halted),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .rf_we       (rf_we)
  );

  // ---------------------------------------------------------------------------
  // Register file attached to the DUT (x0 always reads zero)
  // ---------------------------------------------------------------------------
  logic [31:0] rf_mem [32] = '{default: 32'd0};
  logic        pre_en;
  logic [4:0]  pre_idx;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) begin
      rf_mem[pre_idx] <= pre_data;
    end else if (rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end

  assign rf_rdata = (rf_raddr == 5'd0) ? 32'd0 : rf_mem[rf_raddr];

  // ---------------------------------------------------------------------------
  // Model and scoreboard
  // ---------------------------------------------------------------------------
  logic [31:0] model_rf [32];
  logic [36:0] exp_w_q [$];  // {index, data} of each expected rf write
  logic [1:0]  exp_b_q [$];  // expected bresp
  logic [33:0] exp_r_q [$];  // {rresp, rdata}

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] last_wdata;
  logic [1:0]  last_bresp;
  logic [31:0] last_rdata;
  logic [1:0]  last_rresp;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail_empty(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: DUT produced an event with nothing expected", name);
  endfunction

  // Response rules: out-of-map address -> DECERR, running core -> SLVERR.
  function automatic logic [1:0] model_resp(input logic [11:0] addr);
    if (addr >= 12'h080) return 2'b11;
    if (!core_halted)    return 2'b10;
    return 2'b00;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: compares against the scoreboard on every falling edge
  // ---------------------------------------------------------------------------
  logic       b_hold = 1'b0;
  logic       r_hold = 1'b0;
  logic [1:0] prev_bresp;
  logic [1:0] prev_rresp;
  logic [31:0] prev_rdata;

  always @(negedge clk) begin
    if (rst) begin
      b_hold = 1'b0;
      r_hold = 1'b0;
    end else begin
      if (rf_we) begin
        if (exp_w_q.size() == 0) fail_empty("rf_write");
        else check("rf_write", {27'd0, rf_waddr, rf_wdata}, {27'd0, exp_w_q.pop_front()});
        last_wdata = rf_wdata;
      end
      if (s_bvalid && s_bready) begin
        if (exp_b_q.size() == 0) fail_empty("bresp");
        else check("bresp", {62'd0, s_bresp}, {62'd0, exp_b_q.pop_front()});
        last_bresp = s_bresp;
      end
      if (s_rvalid && s_rready) begin
        if (exp_r_q.size() == 0) fail_empty("rresp");
        else check("rresp_rdata", {30'd0, s_rresp, s_rdata}, {30'd0, exp_r_q.pop_front()});
        last_rdata = s_rdata;
        last_rresp = s_rresp;
      end
      if (b_hold) check("b_stable", {61'd0, s_bvalid, s_bresp}, {61'd0, 1'b1, prev_bresp});
      if (r_hold) check("r_stable", {29'd0, s_rvalid, s_rresp, s_rdata},
                        {29'd0, 1'b1, prev_rresp, prev_rdata});
      b_hold     = s_bvalid && !s_bready;
      r_hold     = s_rvalid && !s_rready;
      prev_bresp = s_bresp;
      prev_rresp = s_rresp;
      prev_rdata = s_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic preload(input logic [4:0] idx, input logic [31:0] data);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_idx = idx; pre_data = data;
    @(posedge clk); #1;
    pre_en = 1'b0;
    model_rf[idx] = data;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {56'd0, s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
          rf_we, s_bresp, s_rresp}, 64'd0);
    check({name, "_data"}, {s_rdata, rf_wdata}, 64'd0);
    check({name, "_idx"}, {54'd0, rf_raddr, rf_waddr}, 64'd0);
  endtask

  // W is offered w_lead cycles before AW; bready is held low b_delay cycles.
  task automatic do_write(input logic [11:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_lead, input int b_delay);
    logic [4:0]  idx;
    logic [1:0]  resp;
    logic        we;
    logic [31:0] mask, merged;
    logic        aw_pend, w_pend, aw_hs, w_hs, hs;
    int          n;
    idx  = addr[6:2];
    resp = model_resp(addr);
    we   = (resp == 2'b00) && (strb != 4'd0) && (idx != 5'd0);
    if (we) begin
      mask   = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      merged = (data & mask) | (model_rf[idx] & ~mask);
      model_rf[idx] = merged;
      exp_w_q.push_back({idx, merged});
    end
    exp_b_q.push_back(resp);

    aw_pend = 1'b1; w_pend = 1'b1; n = 0;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    while ((aw_pend || w_pend) && n < 40) begin
      s_awvalid = aw_pend && (n >= w_lead);
      s_wvalid  = w_pend;
      @(negedge clk);
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      if (s_arvalid) check("ar_blocked", {63'd0, s_arready}, 64'd0);
      @(posedge clk); #1;
      if (aw_hs) aw_pend = 1'b0;
      if (w_hs)  w_pend  = 1'b0;
      n++;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("aw_w_accept", {62'd0, aw_pend, w_pend}, 64'd0);

    @(negedge clk);
    check("we_latency", {63'd0, rf_we}, {63'd0, we});
    @(negedge clk);
    check("b_latency", {63'd0, s_bvalid}, 64'd1);
    repeat (b_delay) @(negedge clk);
    @(posedge clk); #1;
    s_bready = 1'b1; hs = 1'b0; n = 0;
    while (!hs && n < 20) begin
      @(negedge clk);
      hs = s_bvalid;
      @(posedge clk); #1;
      n++;
    end
    s_bready = 1'b0;
    check("b_done", {63'd0, hs}, 64'd1);
  endtask

  task automatic do_read(input logic [11:0] addr, input int r_delay);
    logic [1:0]  resp;
    logic [31:0] data;
    logic        hs;
    int          n;
    resp = model_resp(addr);
    data = (resp == 2'b00) ? model_rf[addr[6:2]] : 32'd0;
    exp_r_q.push_back({resp, data});

    s_araddr = addr; s_arvalid = 1'b1; hs = 1'b0; n = 0;
    while (!hs && n < 40) begin
      @(negedge clk);
      hs = s_arvalid && s_arready;
      @(posedge clk); #1;
      n++;
    end
    s_arvalid = 1'b0;
    check("ar_accept", {63'd0, hs}, 64'd1);

    @(negedge clk);
    check("r_latency1", {63'd0, s_rvalid}, 64'd0);
    @(negedge clk);
    check("r_latency2", {63'd0, s_rvalid}, 64'd1);
    repeat (r_delay) @(negedge clk);
    @(posedge clk); #1;
    s_rready = 1'b1; hs = 1'b0; n = 0;
    while (!hs && n < 20) begin
      @(negedge clk);
      hs = s_rvalid;
      @(posedge clk); #1;
      n++;
    end
    s_rready = 1'b0;
    check("r_done", {63'd0, hs}, 64'd1);
  endtask

  // Reset lands in the write-execute cycle: the write must be dropped.
  task automatic reset_in_wexec();
    @(posedge clk); #1;
    s_awaddr = 12'h020; s_awvalid = 1'b1;
    s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(negedge clk);
    check("rst_w_capture", {62'd0, s_awready, s_wready}, 64'd3);
    @(posedge clk); #2;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("rst_w_exec_we", {63'd0, rf_we}, 64'd1);
    rst = 1'b1;
    #1;
    check_all_zero("rst_wexec");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Reset lands while the read response is held.
  task automatic reset_in_rresp();
    @(posedge clk); #1;
    s_araddr = 12'h014; s_arvalid = 1'b1;
    @(negedge clk);
    check("rst_ar_capture", {63'd0, s_arready}, 64'd1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_rresp_valid", {63'd0, s_rvalid}, 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("rst_rresp");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    core_halted = 1'b1;
    pre_en = 1'b0; pre_idx = '0; pre_data = '0;
    last_wdata = '0; last_bresp = '0; last_rdata = '0; last_rresp = '0;

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    preload(5'd7, 32'h11223344);

    // Full write and read-back of x5.
    do_write(12'h014, 32'hDEADBEEF, 4'hF, 0, 0);
    check("lit_x5_wdata", {32'd0, last_wdata}, 64'h0000_0000_DEAD_BEEF);
    check("lit_x5_stored", {32'd0, rf_mem[5]}, 64'h0000_0000_DEAD_BEEF);
    do_read(12'h014, 0);
    check("lit_x5_rdata", {30'd0, last_rresp, last_rdata}, 64'h0000_0000_DEAD_BEEF);

    // Partial write merges with the current x7 value.
    do_write(12'h01C, 32'hAABBCCDD, 4'b0101, 0, 0);
    check("lit_x7_merge", {32'd0, last_wdata}, 64'h0000_0000_11BB_33DD);

    // x0 write is acknowledged without a write; x0 reads zero.
    do_write(12'h000, 32'hFFFFFFFF, 4'hF, 0, 0);
    check("lit_x0_bresp", {62'd0, last_bresp}, 64'd0);
    do_read(12'h000, 0);

    // Out-of-map addresses.
    do_read(12'h080, 0);
    check("lit_decerr_read", {30'd0, last_rresp, last_rdata}, 64'h3_0000_0000);
    do_write(12'h084, 32'h01020304, 4'hF, 0, 0);
    check("lit_decerr_write", {62'd0, last_bresp}, 64'd3);

    // Core running: SLVERR with no side effect; DECERR still wins.
    core_halted = 1'b0;
    do_write(12'h018, 32'h00000055, 4'hF, 0, 0);
    check("lit_slverr_write", {62'd0, last_bresp}, 64'd2);
    do_read(12'h014, 0);
    check("lit_slverr_read", {30'd0, last_rresp, last_rdata}, 64'h2_0000_0000);
    do_read(12'h100, 0);
    core_halted = 1'b1;

    // Zero strobe: OKAY, nothing written.
    do_write(12'h010, 32'h00000099, 4'h0, 0, 0);
    do_read(12'h010, 0);

    // W three cycles ahead of AW.
    do_write(12'h024, 32'hCAFEF00D, 4'hF, 3, 0);

    // AW+W+AR together: the write must complete before the read is taken.
    s_araddr = 12'h024; s_arvalid = 1'b1;
    do_write(12'h028, 32'h0BADC0DE, 4'hF, 0, 0);
    do_read(12'h024, 0);
    check("lit_x9_rdata", {32'd0, last_rdata}, 64'h0000_0000_CAFE_F00D);
    do_read(12'h028, 0);

    // Response backpressure.
    do_write(12'h02C, 32'h13579BDF, 4'b0011, 0, 5);
    do_read(12'h02C, 4);
    check("lit_x11_rdata", {32'd0, last_rdata}, 64'h0000_0000_0000_9BDF);

    // Reset in the middle of transactions.
    reset_in_wexec();
    check("lit_x8_not_written", {32'd0, rf_mem[8]}, 64'd0);
    do_read(12'h020, 0);
    reset_in_rresp();
    do_read(12'h014, 0);
    check("lit_x5_after_reset", {32'd0, last_rdata}, 64'h0000_0000_DEAD_BEEF);

    repeat (3) @(posedge clk);
    check("exp_w_empty", 64'(exp_w_q.size()), 64'd0);
    check("exp_b_empty", 64'(exp_b_q.size()), 64'd0);
    check("exp_r_empty", 64'(exp_r_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_regfile_dbg_axil.md
Name: riscv_regfile_dbg_axil

Overview:
- AXI4-Lite slave that lets an external debug master read and write x0-x31 of the core register file.
- It is the initiator side of the register file's ports: it drives a read address and a write address/data/enable, and consumes combinational read data.
- It sits between the SoC debug interconnect and the register file. It is muxed onto the register-file ports by core control only while `core_halted` is high.

Parameters:
- ADDR_WIDTH, 12, AXI address width; only bits [6:2] select the register, bits [ADDR_WIDTH-1:7] must be zero.
- REQUIRE_HALT, 1, when 1 every access with `core_halted`=0 returns SLVERR with no side effect; when 0 the halt check is skipped.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- s_awaddr  input  ADDR_WIDTH  write address
- s_awvalid  input  1  write address valid
- s_awready  output  1  write address ready
- s_wdata  input  32  write data
- s_wstrb  input  4  write byte strobes
- s_wvalid  input  1  write data valid
- s_wready  output  1  write data ready
- s_bresp  output  2  write response
- s_bvalid  output  1  write response valid
- s_bready  input  1  write response ready
- s_araddr  input  ADDR_WIDTH  read address
- s_arvalid  input  1  read address valid
- s_arready  output  1  read address ready
- s_rdata  output  32  read data
- s_rresp  output  2  read response
- s_rvalid  output  1  read data valid
- s_rready  input  1  read data ready
- core_halted  input  1  core stopped, register-file ports owned by debug
- rf_raddr  output  5  register-file read index
- rf_rdata  input  32  combinational read data for rf_raddr (x0 reads 0)
- rf_waddr  output  5  register-file write index
- rf_wdata  output  32  register-file write data
- rf_we  output  1  register-file write enable, single-cycle pulse

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All ready/valid outputs and rf_we are 0.
  - s_rdata, s_bresp, s_rresp, rf_raddr, rf_waddr and rf_wdata are 0.
  - Captured AW/W flags are cleared.
  - An in-flight transaction is dropped with no response and no rf write.
- States:
  - IDLE: wait for requests.
  - WCAP: one of AW/W captured.
  - WEXEC: perform the write.
  - WRESP: hold the write response.
  - REXEC: perform the read.
  - RRESP: hold the read response.
- IDLE, AW/W capture:
  - s_awready=1 while AW is not yet captured; s_wready=1 while W is not yet captured. Capture occurs on valid&ready.
  - AW and W may arrive in any order or in the same cycle.
  - When one is captured, go to WCAP. When both are captured, go to WEXEC.
- IDLE, AR capture:
  - s_arready=1 only in IDLE with no AW/W captured and s_awvalid=0, s_wvalid=0. Writes win simultaneous arrivals.
  - On AR capture go to REXEC.
- WEXEC (exactly 1 cycle):
  - Decode: ERR_HALT = REQUIRE_HALT & ~core_halted gives SLVERR (2'b10). ERR_ADDR = nonzero upper bits gives DECERR (2'b11). ERR_ADDR takes priority.
  - If no error and wstrb≠0: rf_raddr=rf_waddr=addr[6:2]. rf_wdata is a per-byte merge: wdata byte where the strobe bit is set, rf_rdata byte otherwise. rf_we=1 for this cycle.
  - wstrb=0 gives OKAY with no write.
  - Index 0 gives OKAY, rf_we stays 0.
  - Then go to WRESP.
- WRESP: s_bvalid=1 with the registered s_bresp; hold until s_bready, then return to IDLE.
- REXEC (exactly 1 cycle):
  - Drive rf_raddr=addr[6:2].
  - Register s_rdata = rf_rdata on OKAY, or 0 on error, using the same error rules as writes.
  - Then go to RRESP.
- RRESP: s_rvalid=1 with s_rdata/s_rresp stable; hold until s_rready, then return to IDLE.
- Latency from the final capture edge:
  - Write: rf_we is high in the next cycle; s_bvalid rises one cycle later.
  - Read: s_rvalid rises two cycles later.
- `core_halted` is sampled only in WEXEC/REXEC. A deassertion earlier in the transaction is irrelevant.
- Throughput: one outstanding transaction total. No new capture while WRESP/RRESP is pending.
- Response stability: response outputs must not change while valid=1 and ready=0.

Test Plan:
- Write with core_halted=1: AW=0x014 and W=0xDEADBEEF/strb=F in the same cycle → rf_we pulse with rf_waddr=5, rf_wdata=0xDEADBEEF, then bresp=OKAY. A read of 0x014 then returns rdata=0xDEADBEEF, rresp=OKAY, rvalid 2 cycles after AR.
- Partial write: rf_rdata for x7 is 0x11223344; write 0x01C with wdata=0xAABBCCDD, strb=0101 → rf_wdata=0x11BB33DD, OKAY.
- Error paths: write 0x000 → OKAY, rf_we never asserts. Read 0x080 → DECERR, rdata=0. Any access with core_halted=0 → SLVERR, no rf_we.
- Ordering and backpressure:
  - W presented 3 cycles before AW → single write, bvalid one cycle after rf_we.
  - Simultaneous AW+W+AR → write completes first, then AR is accepted.
  - bready held low 5 cycles → bvalid/bresp stable throughout.
- Reset: assert rst during WEXEC or RRESP → all outputs 0 immediately (async). After release, the next read completes normally.
